doom_camera_heading: RTL and testbench
======================================

# doom_camera_heading

Parametrised camera-heading controller for the Doom top level: turns BtnL/BtnR/BtnU presses into an N-way player heading with timed turn transitions. It generalises the fixed Forward/Left/Right one-hot camera state machine to NUM_VIEWS headings with wrap-around, a one-deep request buffer and an auto-recentre mode. It feeds `camera_view` to the renderer and debug bench, and `heading` to the SSD display logic.

## Interface
- NUM_VIEWS, 8, number of headings, ≥3; index 0..NUM_VIEWS-1, increasing = clockwise (right)
- TURN_CYCLES, 4, clock cycles per one-step turn, ≥1
- HOME_VIEW, 0, heading after reset and recentre target, < NUM_VIEWS
- Derived: HW = $clog2(NUM_VIEWS); CW = $clog2(TURN_CYCLES+1)

- ClkPort  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset
- BtnL  in  1  debounced level; each rising edge = one left-turn request
- BtnR  in  1  debounced level; each rising edge = one right-turn request
- BtnU  in  1  debounced level; rising edge = recentre request
- camera_view  out  NUM_VIEWS  one-hot heading, bit `heading` set
- heading  out  HW  current heading index
- turning  out  1  high while a turn is in progress
- turn_dir  out  1  1 = right, 0 = left; valid while turning
- turn_phase  out  CW  cycles elapsed in the current turn, 0..TURN_CYCLES-1

## Operation
- Edge detect: registered previous level per button; an edge is cur=1 and prev=0. Prev registers reset to 0, so a button held through reset gives one request.
- States: IDLE, TURN. A turn request is accepted in IDLE, or buffered in TURN.
- IDLE with one L or R edge: go to TURN, turning=1, turn_dir set, turn_phase=0.
- TURN: turn_phase increments each cycle. On the edge where turn_phase==TURN_CYCLES-1:
  - heading becomes heading±1;
  - turn_phase returns to 0;
  - if a request is pending, start it immediately and stay in TURN with no idle cycle; otherwise go to IDLE with turning=0.
- Pending buffer is one deep and the latest request wins. An L/R edge during TURN overwrites the pending entry.
- Simultaneous L and R edges in the same cycle are ignored. A pending entry already stored is unchanged.
- Recentre (BtnU edge):
  - sets the recentre flag;
  - while the flag is set and no turn is pending, each completed turn (or IDLE) launches the next step toward HOME_VIEW by the shortest path;
  - a tie at exactly NUM_VIEWS/2 goes right;
  - the flag clears when heading==HOME_VIEW;
  - BtnU with heading==HOME_VIEW and IDLE is a no-op;
  - an L/R edge clears the flag; the current turn finishes, then the L/R request executes.
- camera_view and heading show the source heading for the whole turn and update only at completion.
- Reset mid-turn: heading returns to HOME_VIEW; the turn, pending request and recentre flag are discarded.

## Timing
- Reset values:
  - heading=HOME_VIEW;
  - camera_view=1<<HOME_VIEW;
  - turning=0, turn_dir=0, turn_phase=0;
  - pending empty, recentre flag 0.
- Edge at clock k (the button is high before edge k and was low at k-1): turning=1 after edge k, and heading updates at edge k+TURN_CYCLES.
- Back-to-back buffered turns: consecutive heading updates exactly TURN_CYCLES cycles apart.
- Throughput: one step per TURN_CYCLES cycles maximum.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- CAMERA_WRAP_EN defined: heading arithmetic is modulo NUM_VIEWS (0-1 → NUM_VIEWS-1, NUM_VIEWS-1+1 → 0). Recentre uses the shortest circular path.
- CAMERA_WRAP_EN undefined: heading saturates at 0 and NUM_VIEWS-1.
  - A request that would move past a limit is dropped at acceptance: no TURN, turning stays 0, and it does not enter the pending buffer.
  - Recentre moves monotonically toward HOME_VIEW.

## Test plan
All scenarios use NUM_VIEWS=8, TURN_CYCLES=4, HOME_VIEW=0.
- Reset release, no buttons → heading=0, camera_view=8'b0000_0001, turning=0.
- BtnR pulse → turning=1 for 4 cycles, turn_phase 0,1,2,3, then heading=1 and camera_view=8'b0000_0010.
- With wrap, BtnL from heading 0 → heading=7. Without wrap → turning stays 0 and heading stays 0.
- BtnR, then BtnR again at turn_phase=1, then BtnL at turn_phase=2 → steps right to 1, then immediately left back to 0; 8 turning cycles total with no gap.
- BtnL and BtnR rising in the same cycle from IDLE at heading 3 → no turn, heading=3.
- With wrap, heading=6, BtnU → two right turns, heading 7 then 0, recentre flag cleared. Reset asserted mid-turn → heading=0 and turning=0 asynchronously.

Source files
------------

// File: rtl/doom_camera_heading.sv
// Camera-heading controller: button edges become timed one-step turns over NUM_VIEWS headings,
// with a one-deep request buffer and recentre. Define CAMERA_WRAP_EN for circular heading arithmetic.
module doom_camera_heading #(
  parameter int NUM_VIEWS   = 8,
  parameter int TURN_CYCLES = 4,
  parameter int HOME_VIEW   = 0,
  localparam int HW = $clog2(NUM_VIEWS),
  localparam int CW = $clog2(TURN_CYCLES + 1)
) (
  input  logic                 ClkPort,
  input  logic                 Reset,
  input  logic                 BtnL,
  input  logic                 BtnR,
  input  logic                 BtnU,
  output logic [NUM_VIEWS-1:0] camera_view,
  output logic [HW-1:0]        heading,
  output logic                 turning,
  output logic                 turn_dir,
  output logic [CW-1:0]        turn_phase
);

  localparam logic [HW-1:0] HOME_H  = HW'(HOME_VIEW);
  localparam logic [HW-1:0] LAST_H  = HW'(NUM_VIEWS - 1);
  localparam logic [CW-1:0] LAST_PH = CW'(TURN_CYCLES - 1);

  typedef enum logic {IDLE, TURN} state_t;

  state_t        state;
  logic          l_prev, r_prev, u_prev;
  logic          l_edge, r_edge, u_edge, one_edge;
  logic          pend_vld, pend_dir, rc_flag;
  logic [HW-1:0] next_h;

  function automatic logic [HW-1:0] step(input logic [HW-1:0] h, input logic dir);
    logic [HW-1:0] r;
`ifdef CAMERA_WRAP_EN
    if (dir) r = (h == LAST_H) ? '0 : h + HW'(1);
    else     r = (h == '0) ? LAST_H : h - HW'(1);
`else
    if (dir) r = (h == LAST_H) ? h : h + HW'(1);
    else     r = (h == '0) ? h : h - HW'(1);
`endif
    return r;
  endfunction

  // A step that saturates in place is a move past a limit.
  function automatic logic can_move(input logic [HW-1:0] h, input logic dir);
    return step(h, dir) != h;
  endfunction

  function automatic logic [NUM_VIEWS-1:0] one_hot(input logic [HW-1:0] h);
    return NUM_VIEWS'(1) << h;
  endfunction

  // Direction of the next recentre step; a half-circle tie goes right.
  function automatic logic rc_dir(input logic [HW-1:0] h);
`ifdef CAMERA_WRAP_EN
    int dist_r;
    dist_r = (HOME_VIEW - int'(h) + NUM_VIEWS) % NUM_VIEWS;
    return dist_r <= NUM_VIEWS / 2;
`else
    return h < HOME_H;
`endif
  endfunction

  assign l_edge   = BtnL & ~l_prev;
  assign r_edge   = BtnR & ~r_prev;
  assign u_edge   = BtnU & ~u_prev;
  assign one_edge = l_edge ^ r_edge;
  assign next_h   = step(heading, turn_dir);

  always_ff @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      l_prev      <= 1'b0;
      r_prev      <= 1'b0;
      u_prev      <= 1'b0;
      pend_vld    <= 1'b0;
      pend_dir    <= 1'b0;
      rc_flag     <= 1'b0;
      heading     <= HOME_H;
      camera_view <= one_hot(HOME_H);
      turning     <= 1'b0;
      turn_dir    <= 1'b0;
      turn_phase  <= '0;
    end else begin
      l_prev <= BtnL;
      r_prev <= BtnR;
      u_prev <= BtnU;
      case (state)
        IDLE: begin
          if (one_edge) begin
            rc_flag <= 1'b0;
            if (can_move(heading, r_edge)) begin
              state      <= TURN;
              turning    <= 1'b1;
              turn_dir   <= r_edge;
              turn_phase <= '0;
            end
          end else if ((rc_flag || u_edge) && heading != HOME_H) begin
            rc_flag    <= 1'b1;
            state      <= TURN;
            turning    <= 1'b1;
            turn_dir   <= rc_dir(heading);
            turn_phase <= '0;
          end else begin
            rc_flag <= 1'b0;
          end
        end
        TURN: begin
          if (turn_phase != LAST_PH) begin
            turn_phase <= turn_phase + CW'(1);
            // Buffered requests are judged against the heading this turn lands on.
            if (one_edge) begin
              rc_flag <= 1'b0;
              if (can_move(next_h, r_edge)) begin
                pend_vld <= 1'b1;
                pend_dir <= r_edge;
              end
            end else if (u_edge) begin
              rc_flag <= 1'b1;
            end
          end else begin
            heading     <= next_h;
            camera_view <= one_hot(next_h);
            turn_phase  <= '0;
            pend_vld    <= 1'b0;
            if (one_edge && can_move(next_h, r_edge)) begin
              rc_flag  <= 1'b0;
              turn_dir <= r_edge;
            end else if (pend_vld) begin
              if (one_edge)    rc_flag <= 1'b0;
              else if (u_edge) rc_flag <= 1'b1;
              turn_dir <= pend_dir;
            end else if (!one_edge && (rc_flag || u_edge) && next_h != HOME_H) begin
              rc_flag  <= 1'b1;
              turn_dir <= rc_dir(next_h);
            end else begin
              rc_flag <= 1'b0;
              state   <= IDLE;
              turning <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_doom_camera_heading.sv
// Bench for doom_camera_heading: cycle model of the turn/pending/recentre rules plus directed literals.
module tb_doom_camera_heading;

  localparam int NV   = 8;
  localparam int TC   = 4;
  localparam int HOME = 0;

  logic       ClkPort, Reset, BtnL, BtnR, BtnU;
  logic [7:0] camera_view;
  logic [2:0] heading;
  logic       turning, turn_dir;
  logic [2:0] turn_phase;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 0;

  doom_camera_heading #(.NUM_VIEWS(NV), .TURN_CYCLES(TC), .HOME_VIEW(HOME)) dut (
    .ClkPort(ClkPort), .Reset(Reset), .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU),
    .camera_view(camera_view), .heading(heading), .turning(turning),
    .turn_dir(turn_dir), .turn_phase(turn_phase)
  );

  initial ClkPort = 0;
  always #5 ClkPort = ~ClkPort;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: heading as an integer, current move as +1/-1/0, elapsed cycles, pending move.
  int mh = HOME, mmove = 0, mel = 0, mpend = 0;
  bit mrc = 0, lp = 0, rp = 0, up = 0;

  function automatic int wadd(int h, int d);
`ifdef CAMERA_WRAP_EN
    return (h + d + NV) % NV;
`else
    return (h + d < 0) ? 0 : (h + d > NV - 1) ? NV - 1 : h + d;
`endif
  endfunction

  function automatic bit legal(int h, int d);
    return wadd(h, d) != h;
  endfunction

  function automatic int home_dir(int h);
`ifdef CAMERA_WRAP_EN
    return (((HOME - h + NV) % NV) <= NV / 2) ? 1 : -1;
`else
    return (h < HOME) ? 1 : -1;
`endif
  endfunction

  always @(posedge ClkPort or negedge Reset) begin
    if (!Reset) begin
      mh = HOME; mmove = 0; mel = 0; mpend = 0; mrc = 0; lp = 0; rp = 0; up = 0;
    end else begin
      int req;
      bit le, re, ue;
      le = BtnL && !lp; re = BtnR && !rp; ue = BtnU && !up;
      lp = BtnL; rp = BtnR; up = BtnU;
      req = (le != re) ? (re ? 1 : -1) : 0;
      if (req != 0) mrc = 0;
      else if (ue)  mrc = 1;
      if (mmove != 0 && mel < TC - 1) begin
        mel++;
        if (req != 0 && legal(wadd(mh, mmove), req)) mpend = req;
      end else begin
        if (mmove != 0) begin
          mh = wadd(mh, mmove); mmove = 0; mel = 0;
        end
        if (req != 0 && legal(mh, req)) mmove = req;
        else if (mpend != 0)            mmove = mpend;
        else if (mrc && mh != HOME)     mmove = home_dir(mh);
        else                            mrc = 0;
        mpend = 0;
      end
    end
  end

  always @(negedge ClkPort) begin
    if (cmp_en) begin
      check("heading", heading, mh);
      check("camera_view", camera_view, 1 << mh);
      check("turning", turning, mmove != 0);
      check("turn_phase", turn_phase, (mmove != 0) ? mel : 0);
      if (mmove != 0) check("turn_dir", turn_dir, mmove > 0);
    end
  end

  task automatic pulse(input bit l, input bit r, input bit u);
    @(negedge ClkPort); #1; BtnL = l; BtnR = r; BtnU = u;
    @(negedge ClkPort); #1; BtnL = 0; BtnR = 0; BtnU = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge ClkPort);
      n++;
    end while (turning && n < 200);
    check("idle_within_bound", turning, 0);
  endtask

  int cnt;

  initial begin
    Reset = 0; BtnL = 0; BtnR = 0; BtnU = 0;
    cmp_en = 1;
    repeat (3) @(negedge ClkPort);
    #1 Reset = 1;

    // Reset state
    @(negedge ClkPort);
    check("rst_heading", heading, 0);
    check("rst_view", camera_view, 8'b0000_0001);
    check("rst_turning", turning, 0);
    check("rst_phase", turn_phase, 0);

    // Single right turn, phase 0..3 then heading 1
    #1 BtnR = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ClkPort);
      check("r_turning", turning, 1);
      check("r_phase", turn_phase, i);
      if (i == 0) begin #1 BtnR = 0; end
    end
    @(negedge ClkPort);
    check("r_heading", heading, 1);
    check("r_view", camera_view, 8'b0000_0010);
    check("r_done", turning, 0);

    // Left back to 0, then left from 0 (wraps or is dropped)
    pulse(1, 0, 0);
    wait_idle();
    check("l_heading", heading, 0);
    pulse(1, 0, 0);
`ifdef CAMERA_WRAP_EN
    check("l0_turning", turning, 1);
    wait_idle();
    check("l0_heading", heading, 7);
    pulse(0, 1, 0);
    wait_idle();
`else
    check("l0_turning", turning, 0);
    wait_idle();
    check("l0_heading", heading, 0);
`endif

    // R, R at phase 1, L at phase 2: latest wins, 8 contiguous turning cycles
    @(negedge ClkPort); #1 BtnR = 1;
    cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge ClkPort);
      if (turning) cnt++;
      if (i == 5) begin
        check("buf_mid_heading", heading, 1);
        check("buf_mid_dir", turn_dir, 0);
      end
      #1;
      case (i)
        1: BtnR = 0;
        2: BtnR = 1;
        3: begin BtnR = 0; BtnL = 1; end
        4: BtnL = 0;
        default: ;
      endcase
    end
    check("buf_cycles", cnt, 8);
    check("buf_heading", heading, 0);

    // Walk to 3, then simultaneous L+R is ignored
    repeat (3) begin pulse(0, 1, 0); wait_idle(); end
    check("h3", heading, 3);
    pulse(1, 1, 0);
    check("lr_turning", turning, 0);
    repeat (3) @(negedge ClkPort);
    check("lr_heading", heading, 3);

    // Walk to 6, recentre
    repeat (3) begin pulse(0, 1, 0); wait_idle(); end
    check("h6", heading, 6);
    pulse(0, 0, 1);
    repeat (4) @(negedge ClkPort);
`ifdef CAMERA_WRAP_EN
    check("rc_first", heading, 7);
`else
    check("rc_first", heading, 5);
`endif
    check("rc_continuing", turning, 1);
    wait_idle();
    check("rc_home", heading, 0);
    pulse(0, 0, 1);
    check("rc_noop", turning, 0);
    wait_idle();

    // Async reset mid-turn, with BtnR held through release
    pulse(0, 1, 0);
    wait_idle();
    pulse(0, 1, 0);
    @(negedge ClkPort); #1 Reset = 0;
    #1;
    check("arst_heading", heading, 0);
    check("arst_turning", turning, 0);
    check("arst_view", camera_view, 8'b0000_0001);
    BtnR = 1;
    repeat (2) @(negedge ClkPort);
    #1 Reset = 1;
    @(negedge ClkPort);
    check("held_turning", turning, 1);
    wait_idle();
    repeat (4) @(negedge ClkPort);
    check("held_heading", heading, 1);
    #1 BtnR = 0;
    repeat (3) @(negedge ClkPort);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
